// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT-80 constants, S-box table and key-schedule state encoding.
package present_pkg;
    localparam int KEY_W   = 80;
    localparam int RKEY_W  = 64;
    localparam int ROUND_W = 6;
    localparam logic [3:0] PRESENT_SBOX [0:15] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    typedef enum logic [1:0] {IDLE, STEP, RUN, DONE} state_e;
endpackage

// File: rtl/present_key_update.sv
// present_key_update: one combinational PRESENT-80 key-schedule update (rotate, S-box, counter XOR).
module present_key_update
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [4:0]       round_i,
    output logic [KEY_W-1:0] key_o
);
    logic [KEY_W-1:0] rot;
    always_comb begin
        rot   = {key_i[18:0], key_i[79:19]};
        key_o = {PRESENT_SBOX[rot[79:76]], rot[75:20], rot[19:15] ^ round_i, rot[14:0]};
    end
endmodule

// File: rtl/present_key_schedule.sv
// present_key_schedule: PRESENT-80 round-key generator with per-request stepping
// and an autonomous fast-forward to K32 for decryption.
module present_key_schedule
    import present_pkg::*;
#(
    parameter int NUM_ROUNDS = 32
) (
    input  logic              inClk,
    input  logic              inRstN,
    input  logic              inKeyValid,
    output logic              outKeyReady,
    input  logic [KEY_W-1:0]  inKey,
    input  logic              inMode,
    input  logic              inNext,
    output logic [KEY_W-1:0]  outKeyState,
    output logic [RKEY_W-1:0] outRoundKey,
    output logic              outRoundKeyValid,
    output logic [ROUND_W-1:0] outRound,
    output logic [RKEY_W-1:0] outLastKey,
    output logic              outDone
);
    localparam logic [ROUND_W-1:0] LAST_UPD = ROUND_W'(NUM_ROUNDS - 1);

    state_e               state_q, state_d;
    logic [KEY_W-1:0]     key_q, key_d, key_upd;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [RKEY_W-1:0]    last_q, last_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 accept;

    present_key_update u_upd (
        .key_i   (key_q),
        .round_i (round_q[4:0]),
        .key_o   (key_upd)
    );

    assign outKeyReady      = state_q != RUN;
    assign accept           = inKeyValid && outKeyReady;
    assign outKeyState      = key_q;
    assign outRoundKey      = key_q[79:16];
    assign outRoundKeyValid = valid_q;
    assign outRound         = round_q;
    assign outLastKey       = last_q;
    assign outDone          = done_q;

    // A reload always wins over an advance; the counter stops at NUM_ROUNDS by leaving for DONE.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        last_d  = last_q;
        if (accept) begin
            state_d = inMode ? RUN : STEP;
            key_d   = inKey;
            round_d = ROUND_W'(1);
        end else if ((state_q == STEP && inNext) || state_q == RUN) begin
            key_d   = key_upd;
            round_d = round_q + ROUND_W'(1);
            if (round_q == LAST_UPD) begin
                last_d  = key_upd[79:16];
                state_d = DONE;
            end
        end
        valid_d = state_d == STEP || state_d == DONE;
        done_d  = state_d == DONE;
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end
endmodule
